elvds_iddr_rx: RTL and testbench



---
 rtl/elvds_rx_pkg.sv | 14 +
 rtl/elvds_rx_frontend.sv | 36 +++
 rtl/elvds_iddr_rx.sv | 135 +++++++++++++
 tb/tb_elvds_iddr_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/elvds_rx_pkg.sv
// rtl/elvds_rx_pkg.sv - shared framing state and default link parameters for the ELVDS receiver
package elvds_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOCK  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
  localparam int unsigned DEF_FRAME_LEN = 4;
  localparam int unsigned DEF_MAX_MISS  = 2;

endpackage

// File: rtl/elvds_rx_frontend.sv
// rtl/elvds_rx_frontend.sv - differential input buffer and DDR capture, one bit pair per clk
module elvds_rx_frontend (
  input  logic clk,
  input  logic rst_n,
  input  logic elvds_p,
  input  logic elvds_n,
  output logic q0,
  output logic q1
);

  logic din;
  logic fall_q;

  // Differential receiver: a '1' is true leg high with complement low.
  assign din = elvds_p & ~elvds_n;

  // Earlier bit is captured on the falling edge, later bit on the rising edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0 <= 1'b0;
      q1 <= 1'b0;
    end else begin
      q0 <= fall_q;
      q1 <= din;
    end
  end

endmodule

// File: rtl/elvds_iddr_rx.sv
// rtl/elvds_iddr_rx.sv - DDR deserialiser with sync-word framing, lock tracking and payload strobes
module elvds_iddr_rx
  import elvds_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD = DEF_SYNC_WORD,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned MAX_MISS  = DEF_MAX_MISS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       elvds_p,
  input  logic       elvds_n,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_start_o,
  output logic       locked_o,
  output logic [3:0] miss_cnt_o
);

  localparam logic [7:0] LAST_WC  = 8'(FRAME_LEN - 1);
  localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);

  logic       q0;
  logic       q1;
  logic [8:0] sr;
  logic       phase;
  logic [1:0] slot;
  logic [7:0] wc;
  logic [3:0] miss_cnt;
  logic [3:0] miss_inc;
  logic [7:0] cand;
  logic       hit0;
  logic       hit1;
  logic       word_done;
  logic       cand_sync;
  logic       emit;
  logic       emit_first;
  logic       lose_lock;
  rx_state_t  state;
  rx_state_t  state_nxt;

  elvds_rx_frontend u_frontend (
    .clk     (clk),
    .rst_n   (rst_n),
    .elvds_p (elvds_p),
    .elvds_n (elvds_n),
    .q0      (q0),
    .q1      (q1)
  );

  // Only sr[8:0] ever feeds a candidate, so the oldest stored bit is bit 8.
  assign hit0      = (sr[7:0] == SYNC_WORD);
  assign hit1      = (sr[8:1] == SYNC_WORD);
  assign cand      = phase ? sr[8:1] : sr[7:0];
  assign word_done = (slot == 2'd3);
  assign cand_sync = (cand == SYNC_WORD);
  assign miss_inc  = miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (hit0 || hit1) state_nxt = LOCK;
      LOCK:    if (word_done && (wc == LAST_WC)) state_nxt = CHECK;
      CHECK:   if (word_done) state_nxt = lose_lock ? HUNT : LOCK;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    emit       = (state == LOCK) && word_done;
    emit_first = emit && (wc == 8'd0);
    lose_lock  = (state == CHECK) && word_done && !cand_sync && (miss_inc == MISS_LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr            <= '0;
      phase         <= 1'b0;
      slot          <= 2'd0;
      wc            <= 8'd0;
      miss_cnt      <= 4'd0;
      data_o        <= 8'd0;
      valid_o       <= 1'b0;
      frame_start_o <= 1'b0;
      locked_o      <= 1'b0;
    end else begin
      sr            <= {sr[6:0], q0, q1};
      valid_o       <= emit;
      frame_start_o <= emit_first;
      locked_o      <= (state != HUNT);
      if (emit) begin
        data_o <= cand;
      end
      case (state)
        HUNT: begin
          if (hit0 || hit1) begin
            phase    <= !hit0;
            slot     <= 2'd0;
            wc       <= 8'd0;
            miss_cnt <= 4'd0;
          end
        end
        LOCK: begin
          slot <= slot + 2'd1;
          if (word_done) begin
            wc <= (wc == LAST_WC) ? 8'd0 : wc + 8'd1;
          end
        end
        CHECK: begin
          slot <= slot + 2'd1;
          // A missed sync slot is consumed so the following frame keeps its timing.
          if (word_done) begin
            if (cand_sync || lose_lock) begin
              miss_cnt <= 4'd0;
            end else begin
              miss_cnt <= miss_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_elvds_iddr_rx.sv
// tb/tb_elvds_iddr_rx.sv - self-checking bench for elvds_iddr_rx framing and deserialisation
`timescale 1ns/1ps
module tb_elvds_iddr_rx;

  logic       clk;
  logic       rst_n;
  logic       elvds_p;
  logic       elvds_n;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_start_o;
  logic       locked_o;
  logic [3:0] miss_cnt_o;

  elvds_iddr_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .elvds_p       (elvds_p),
    .elvds_n       (elvds_n),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .frame_start_o (frame_start_o),
    .locked_o      (locked_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       first;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       fs;
    logic       locked;
    int         cyc;
  } obs_t;

  typedef struct {
    int         pre;
    logic [7:0] w [6];
    logic       payload;
    logic       exp_lock;
    logic [3:0] exp_miss;
  } vec_t;

  bit   bits[$];
  int   bp = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int   ri = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_cyc = 0;
  bit   have_last = 0;

  // Serial driver: earlier bit in the first half-cycle, later bit in the second.
  initial begin
    elvds_p = 1'b0;
    elvds_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      elvds_p = (bp < bits.size()) ? bits[bp] : 1'b0;
      elvds_n = ~elvds_p;
      if (bp < bits.size()) bp++;
      @(negedge clk);
      #1;
      elvds_p = (bp < bits.size()) ? bits[bp] : 1'b0;
      elvds_n = ~elvds_p;
      if (bp < bits.size()) bp++;
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid_o) obs_q.push_back('{data_o, frame_start_o, locked_o, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bits.push_back(w[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bits.push_back(1'b0);
  endtask

  task automatic drain(input bit final_chk);
    exp_t e;
    obs_t o;
    while (ri < obs_q.size()) begin
      o = obs_q[ri];
      ri++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {24'd0, o.data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data", {23'd0, o.fs, o.data}, {23'd0, e.first, e.data});
        chk("locked_at_valid", {31'd0, o.locked}, 32'd1);
        if (have_last) chk("strobe_spacing_ok", {31'd0, (o.cyc - last_cyc) >= 4}, 32'd1);
      end
      last_cyc  = o.cyc;
      have_last = 1'b1;
    end
    if (final_chk) chk("missing_words", exp_q.size(), 0);
  endtask

  // Waits until at most n bits are still queued, then lets the pipeline settle.
  task automatic wait_left(input int n);
    int guard = 0;
    while ((bits.size() - bp) > n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_timeout", guard >= 5000, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ri        = obs_q.size();
    have_last = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input bit rst);
    if (rst) do_reset();
    push_zeros(16 + v.pre);
    for (int i = 0; i < 6; i++) push_word(v.w[i]);
    if (v.pre % 2 != 0) push_zeros(1);
    if (v.payload) begin
      for (int i = 1; i <= 4; i++) exp_q.push_back('{v.w[i], i == 1});
    end
    wait_left(0);
    chk("vec_locked", {31'd0, locked_o}, {31'd0, v.exp_lock});
    chk("vec_miss", {28'd0, miss_cnt_o}, {28'd0, v.exp_miss});
    drain(1'b1);
  endtask

  initial begin
    vec_t vecs[5];
    rst_n = 1'b0;

    vecs[0] = '{0, '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5}, 1'b1, 1'b1, 4'd0};
    vecs[1] = '{1, '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5}, 1'b1, 1'b1, 4'd0};
    vecs[2] = '{4, '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5}, 1'b1, 1'b1, 4'd0};
    vecs[3] = '{0, '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hFF, 8'hA5}, 1'b1, 1'b1, 4'd0};
    vecs[4] = '{3, '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5}, 1'b0, 1'b1, 4'd0};

    // Reset state and idle line.
    do_reset();
    chk("reset_outputs", {17'd0, data_o, valid_o, frame_start_o, locked_o, miss_cnt_o}, 32'd0);
    repeat (50) @(negedge clk);
    chk("idle_locked", {31'd0, locked_o}, 32'd0);
    chk("idle_miss", {28'd0, miss_cnt_o}, 32'd0);
    drain(1'b1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

    // One missed sync keeps lock; a second consecutive miss drops back to hunting.
    do_reset();
    push_zeros(16);
    push_word(8'hA5);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    push_word(8'h5A);
    push_word(8'h55); push_word(8'h66); push_word(8'h77); push_word(8'h88);
    push_word(8'h5A);
    push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04);
    push_word(8'h5A);
    exp_q.push_back('{8'h11, 1'b1}); exp_q.push_back('{8'h22, 1'b0});
    exp_q.push_back('{8'h33, 1'b0}); exp_q.push_back('{8'h44, 1'b0});
    exp_q.push_back('{8'h55, 1'b1}); exp_q.push_back('{8'h66, 1'b0});
    exp_q.push_back('{8'h77, 1'b0}); exp_q.push_back('{8'h88, 1'b0});
    wait_left(80);
    chk("miss1_cnt", {28'd0, miss_cnt_o}, 32'd1);
    chk("miss1_locked", {31'd0, locked_o}, 32'd1);
    drain(1'b0);
    wait_left(40);
    chk("miss2_cnt", {28'd0, miss_cnt_o}, 32'd0);
    chk("miss2_locked", {31'd0, locked_o}, 32'd0);
    wait_left(0);
    repeat (20) @(negedge clk);
    chk("hunt_locked", {31'd0, locked_o}, 32'd0);
    drain(1'b1);

    // Reset pulse in the middle of a frame, then a fresh frame on the same stream.
    do_reset();
    push_zeros(16);
    push_word(8'hA5);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    wait_left(16);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_outputs", {17'd0, data_o, valid_o, frame_start_o, locked_o, miss_cnt_o}, 32'd0);
    rst_n     = 1'b1;
    ri        = obs_q.size();
    have_last = 1'b0;
    exp_q.delete();
    wait_left(0);
    ri = obs_q.size();
    run_vec(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
